mips_instr_encoder: RTL and testbench
=====================================

MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_3000, address of first emitted word.
REQ-002 clk  in  1  sole clock, rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  encoder can accept a request this cycle.
REQ-006 in_op  in  5  operation code: 0 nop, 1 add, 2 addu, 3 sub, 4 subu, 5 and, 6 or, 7 slt, 8 jr, 9 lw, 10 sw, 11 beq, 12 addi, 13 ori, 14 lui, 15 j, 16 jal, 17 li, 18-31 illegal.
REQ-007 in_rs / in_rt / in_rd  in  5 each  register fields.
REQ-008 in_imm  in  32  immediate/offset/target (low 16 for I-type, full 32 for li/j/jal).
REQ-009 out_valid  out  1  instruction word present.
REQ-010 out_ready  in  1  consumer accepts word.
REQ-011 out_instr  out  32  encoded MIPS word.
REQ-012 out_addr  out  32  instruction-memory address of out_instr.
REQ-013 err  out  1  one-cycle pulse on illegal request.

Function
REQ-014 Transfer on either port occurs when valid and ready are both high at a rising edge.
REQ-015 R-type (add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, slt 0x2A): op 0, rs, rt, rd, shamt 0, funct as listed; jr: op 0, rs, rt=rd=shamt=0, funct 0x08.
REQ-016 I-type opcodes: lw 0x23, sw 0x2B, beq 0x04, addi 0x08, ori 0x0D, lui 0x0F (rs forced 0); imm field = in_imm[15:0].
REQ-017 J-type: j 0x02, jal 0x03, target field = in_imm[27:2].
REQ-018 nop encodes 32'h0000_0000.
REQ-019 li expands to two words: lui rt,in_imm[31:16] then ori rt,rt,in_imm[15:0], always both, in that order.
REQ-020 States: EMPTY (no word held), FULL (one word held), FULL_LI (lui held, ori pending internally).
REQ-021 Latency: word appears on out_instr with out_valid the cycle after input acceptance.
REQ-022 in_ready = EMPTY, or FULL with out_ready high (pass-through acceptance); low in FULL_LI.
REQ-023 FULL_LI: on output transfer, ori word loaded, state FULL; no new request accepted that cycle.
REQ-024 out_instr, out_addr stable while out_valid high and out_ready low.
REQ-025 out_addr starts at BASE_ADDR, increments by 4 per output transfer, wraps modulo 2^32.
REQ-026 Illegal in_op: accepted (in_ready rules unchanged), no word produced, err high exactly one cycle after acceptance, address unchanged.
REQ-027 Output transfer and input acceptance in the same cycle: new word replaces old, no bubble, no loss.

Reset
REQ-028 rst_n low: state EMPTY, out_valid 0, out_instr 0, out_addr BASE_ADDR, err 0, in_ready 0 while asserted, 1 from first edge after release.
REQ-029 Reset during FULL_LI discards pending ori; no partial pair emitted after release.

Configuration
REQ-030 Macro MIPS_ENC_LI_EXPAND_EN defined: li handled per REQ-019; undefined: in_op 17 treated as illegal per REQ-026 and FULL_LI state absent.

Structure
REQ-031 Shared package holds in_op code constants, MIPS opcode/funct constants, state encoding.
REQ-032 One combinational sub-module mips_field_pack (op/fields -> 32-bit word, single-word ops); sequencing, li expansion, addressing stay in top.

Verification
REQ-033 add rs=1 rt=2 rd=3, out_ready=1 -> 0x00221820 at addr 0x00003000 one cycle later.
REQ-034 ori rt=1 rs=0 imm=0x1234 then lui rt=1 imm=0xABCD back-to-back -> 0x34011234 @0x3000, 0x3C01ABCD @0x3004, no bubble.
REQ-035 li rt=5 imm=0x12345678 with out_ready low 3 cycles -> 0x3C051234 held stable, in_ready low, then 0x34A55678 @+4; with macro undefined -> err pulse, no output.
REQ-036 j imm=0x00003008 then jal same -> 0x08000C02, 0x0C000C02.
REQ-037 in_op=25 -> err one cycle, out_valid stays 0, next legal word uses unchanged address.
REQ-038 rst_n asserted while FULL_LI -> out_valid 0 immediately, out_addr 0x3000, no ori after release.

Source files
------------

// File: rtl/mips_instr_encoder_pkg.sv
// mips_instr_encoder_pkg
// Shared constants for the MIPS instruction encoder:
//   - request operation codes carried on in_op
//   - MIPS primary opcodes and R-type funct codes
//   - encoder state encoding
//   - small helpers that assemble R-type and I-type words
// Optional feature macro: MIPS_ENC_LI_EXPAND_EN (adds the li pseudo-op and its extra state).
package mips_instr_encoder_pkg;

    // Request operation codes (in_op)
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_ADDU = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_SUBU = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SLT  = 5'd7;
    localparam logic [4:0] OP_JR   = 5'd8;
    localparam logic [4:0] OP_LW   = 5'd9;
    localparam logic [4:0] OP_SW   = 5'd10;
    localparam logic [4:0] OP_BEQ  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_LUI  = 5'd14;
    localparam logic [4:0] OP_J    = 5'd15;
    localparam logic [4:0] OP_JAL  = 5'd16;
    localparam logic [4:0] OP_LI   = 5'd17;

    // MIPS primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    // Encoder state: StFull holds one word; StFullLi holds the lui half of li
    // with the ori half waiting in a side register.
`ifdef MIPS_ENC_LI_EXPAND_EN
    typedef enum logic [1:0] {StEmpty, StFull, StFullLi} enc_state_e;
`else
    typedef enum logic [1:0] {StEmpty, StFull} enc_state_e;
`endif

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_field_pack.sv
// mips_field_pack
// Purely combinational packer: turns one single-word request into a 32-bit MIPS word.
// Multi-word pseudo-ops (li) are not handled here and report legal = 0.
// Ports:
//   op     in  5   request operation code
//   rs/rt/rd in 5  register fields
//   imm16  in  16  I-type immediate / offset
//   target in  26  J-type target field (word address bits 27:2)
//   word   out 32  encoded instruction
//   legal  out 1   op is a known single-word operation
module mips_field_pack
    import mips_instr_encoder_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm16,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        case (op)
            OP_NOP:  word = 32'h0000_0000;
            OP_ADD:  word = r_word(rs, rt, rd, FUNCT_ADD);
            OP_ADDU: word = r_word(rs, rt, rd, FUNCT_ADDU);
            OP_SUB:  word = r_word(rs, rt, rd, FUNCT_SUB);
            OP_SUBU: word = r_word(rs, rt, rd, FUNCT_SUBU);
            OP_AND:  word = r_word(rs, rt, rd, FUNCT_AND);
            OP_OR:   word = r_word(rs, rt, rd, FUNCT_OR);
            OP_SLT:  word = r_word(rs, rt, rd, FUNCT_SLT);
            OP_JR:   word = r_word(rs, 5'd0, 5'd0, FUNCT_JR);
            OP_LW:   word = i_word(OPC_LW, rs, rt, imm16);
            OP_SW:   word = i_word(OPC_SW, rs, rt, imm16);
            OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm16);
            OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm16);
            OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm16);
            OP_LUI:  word = i_word(OPC_LUI, 5'd0, rt, imm16);
            OP_J:    word = {OPC_J, target};
            OP_JAL:  word = {OPC_JAL, target};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Accepts encode requests on a valid/ready input port and emits MIPS instruction words,
// each tagged with its instruction-memory address, on a valid/ready output port.
// One output word is buffered; a new request may be accepted in the same cycle the held
// word leaves, so a continuous stream has no bubbles.
// Optional feature macro: MIPS_ENC_LI_EXPAND_EN -- when defined, in_op 17 (li) expands to
// lui rt,imm[31:16] followed by ori rt,rt,imm[15:0]; when undefined, in_op 17 is illegal.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake
//   in_op, in_rs, in_rt, in_rd, in_imm  request fields
//   out_valid/out_ready output handshake
//   out_instr, out_addr encoded word and its address
//   err               one-cycle pulse after an illegal request is accepted
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err
);

    enc_state_e  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        ready_en_q;

    logic [31:0] pack_word;
    logic        pack_legal;
    logic        req_legal;
    logic        accept;
    logic        out_fire;

    // Only bits 31:16 (li) and 27:2 / 15:0 are meaningful.
    logic unused_imm;
    assign unused_imm = ^{in_imm[31:28], in_imm[1:0]};

    mips_field_pack u_field_pack (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm16  (in_imm[15:0]),
        .target (in_imm[27:2]),
        .word   (pack_word),
        .legal  (pack_legal)
    );

`ifdef MIPS_ENC_LI_EXPAND_EN
    logic [31:0] ori_q, ori_d;
    logic        is_li;
    assign is_li     = (in_op == OP_LI);
    assign req_legal = pack_legal | is_li;
`else
    assign req_legal = pack_legal;
`endif

    assign out_valid = (state_q != StEmpty);
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err       = err_q;

    // ready_en_q keeps in_ready low until the first clock edge after reset release.
    assign in_ready = ready_en_q &
                      ((state_q == StEmpty) | ((state_q == StFull) & out_ready));
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = accept & ~req_legal;
`ifdef MIPS_ENC_LI_EXPAND_EN
        ori_d   = ori_q;
`endif

        if (out_fire) begin
            addr_d = addr_q + 32'd4;
        end

        case (state_q)
            StEmpty, StFull: begin
                if (out_fire) begin
                    state_d = StEmpty;
                end
                // Pass-through: a legal request replaces the departing word in the same edge.
                if (accept && req_legal) begin
`ifdef MIPS_ENC_LI_EXPAND_EN
                    if (is_li) begin
                        instr_d = i_word(OPC_LUI, 5'd0, in_rt, in_imm[31:16]);
                        ori_d   = i_word(OPC_ORI, in_rt, in_rt, in_imm[15:0]);
                        state_d = StFullLi;
                    end else begin
                        instr_d = pack_word;
                        state_d = StFull;
                    end
`else
                    instr_d = pack_word;
                    state_d = StFull;
`endif
                end
            end
`ifdef MIPS_ENC_LI_EXPAND_EN
            StFullLi: begin
                // in_ready is low here, so only the ori half can move in.
                if (out_fire) begin
                    instr_d = ori_q;
                    state_d = StFull;
                end
            end
`endif
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            instr_q    <= 32'h0000_0000;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
        end
    end

`ifdef MIPS_ENC_LI_EXPAND_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ori_q <= 32'h0000_0000;
        end else begin
            ori_q <= ori_d;
        end
    end
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder
// Directed self-checking bench for mips_instr_encoder with hand-computed expected words.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Honours MIPS_ENC_LI_EXPAND_EN the same way the design does.
module tb_mips_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_addr;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    mips_instr_encoder #(
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
        in_valid = v;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    endtask

    initial begin
        // Streamed back-to-back with out_ready high; first two are ori then lui.
        vecs[0]  = '{5'd13, 5'd0,  5'd1, 5'd0, 32'h0000_1234, 32'h3401_1234};
        vecs[1]  = '{5'd14, 5'd0,  5'd1, 5'd0, 32'h0000_ABCD, 32'h3C01_ABCD};
        vecs[2]  = '{5'd15, 5'd0,  5'd0, 5'd0, 32'h0000_3008, 32'h0800_0C02};
        vecs[3]  = '{5'd16, 5'd0,  5'd0, 5'd0, 32'h0000_3008, 32'h0C00_0C02};
        vecs[4]  = '{5'd9,  5'd29, 5'd8, 5'd0, 32'h0000_0004, 32'h8FA8_0004};
        vecs[5]  = '{5'd10, 5'd29, 5'd8, 5'd0, 32'h0000_FFFC, 32'hAFA8_FFFC};
        vecs[6]  = '{5'd11, 5'd1,  5'd2, 5'd0, 32'h0000_0003, 32'h1022_0003};
        vecs[7]  = '{5'd8,  5'd31, 5'd7, 5'd9, 32'h0000_0000, 32'h03E0_0008};
        vecs[8]  = '{5'd3,  5'd4,  5'd5, 5'd6, 32'h0000_0000, 32'h0085_3022};
        vecs[9]  = '{5'd7,  5'd1,  5'd2, 5'd3, 32'h0000_0000, 32'h0022_182A};
        vecs[10] = '{5'd12, 5'd0,  5'd1, 5'd0, 32'hFFFF_FFFF, 32'h2001_FFFF};
        vecs[11] = '{5'd0,  5'd3,  5'd3, 5'd3, 32'h1234_5678, 32'h0000_0000};

        // Reset state
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle();
        #12;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_instr", out_instr, 32'h0);
        check_eq("rst_out_addr", out_addr, BASE);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        exp_addr = BASE;

        // add rs=1 rt=2 rd=3
        out_ready = 1'b1;
        drive(1'b1, 5'd1, 5'd1, 5'd2, 5'd3, 32'h0);
        step();
        check_eq("add_valid", {31'd0, out_valid}, 32'd1);
        check_eq("add_instr", out_instr, 32'h0022_1820);
        check_eq("add_addr", out_addr, exp_addr);
        idle();
        step();
        exp_addr += 32'd4;
        check_eq("add_drain_valid", {31'd0, out_valid}, 32'd0);
        check_eq("add_drain_addr", out_addr, exp_addr);

        // Back-to-back stream, no bubbles
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
            step();
            check_eq($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("stream%0d_instr", i), out_instr, vecs[i].word);
            check_eq($sformatf("stream%0d_addr", i), out_addr, exp_addr);
            exp_addr += 32'd4;
        end
        idle();
        step();
        check_eq("stream_drain_valid", {31'd0, out_valid}, 32'd0);
        check_eq("stream_drain_addr", out_addr, exp_addr);

        // Stall: held word stable, pending request waits, then passes through
        out_ready = 1'b0;
        drive(1'b1, 5'd6, 5'd1, 5'd2, 5'd3, 32'h0);
        step();
        drive(1'b1, 5'd5, 5'd4, 5'd5, 5'd6, 32'h0);
        for (int k = 0; k < 2; k++) begin
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall_instr", out_instr, 32'h0022_1825);
            check_eq("stall_addr", out_addr, exp_addr);
            step();
        end
        out_ready = 1'b1;
        #1;
        check_eq("stall_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        exp_addr += 32'd4;
        check_eq("pass_instr", out_instr, 32'h0085_3024);
        check_eq("pass_addr", out_addr, exp_addr);
        idle();
        step();
        exp_addr += 32'd4;
        check_eq("pass_drain_valid", {31'd0, out_valid}, 32'd0);

`ifdef MIPS_ENC_LI_EXPAND_EN
        // li rt=5 imm=0x12345678 with out_ready low for 3 cycles
        out_ready = 1'b0;
        drive(1'b1, 5'd17, 5'd0, 5'd5, 5'd0, 32'h1234_5678);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            check_eq("li_lui_valid", {31'd0, out_valid}, 32'd1);
            check_eq("li_lui_instr", out_instr, 32'h3C05_1234);
            check_eq("li_lui_addr", out_addr, exp_addr);
            check_eq("li_in_ready", {31'd0, in_ready}, 32'd0);
            if (k < 2) step();
        end
        out_ready = 1'b1;
        #1;
        check_eq("li_in_ready_out_ready", {31'd0, in_ready}, 32'd0);
        step();
        exp_addr += 32'd4;
        check_eq("li_ori_instr", out_instr, 32'h34A5_5678);
        check_eq("li_ori_addr", out_addr, exp_addr);
        step();
        exp_addr += 32'd4;
        check_eq("li_drain_valid", {31'd0, out_valid}, 32'd0);
`else
        // li without the expansion feature is an illegal op
        out_ready = 1'b1;
        drive(1'b1, 5'd17, 5'd0, 5'd5, 5'd0, 32'h1234_5678);
        step();
        check_eq("li_err", {31'd0, err}, 32'd1);
        check_eq("li_no_valid", {31'd0, out_valid}, 32'd0);
        idle();
        step();
        check_eq("li_err_clear", {31'd0, err}, 32'd0);
        check_eq("li_addr_kept", out_addr, exp_addr);
`endif

        // Illegal in_op 25
        out_ready = 1'b1;
        drive(1'b1, 5'd25, 5'd1, 5'd2, 5'd3, 32'h0);
        step();
        check_eq("ill_err", {31'd0, err}, 32'd1);
        check_eq("ill_no_valid", {31'd0, out_valid}, 32'd0);
        idle();
        step();
        check_eq("ill_err_clear", {31'd0, err}, 32'd0);
        check_eq("ill_no_valid2", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 5'd2, 5'd7, 5'd8, 5'd9, 32'h0);
        step();
        check_eq("post_ill_instr", out_instr, 32'h00E8_4821);
        check_eq("post_ill_addr", out_addr, exp_addr);
        idle();
        step();

        // Reset while holding a word (li pair when enabled)
        out_ready = 1'b0;
`ifdef MIPS_ENC_LI_EXPAND_EN
        drive(1'b1, 5'd17, 5'd0, 5'd5, 5'd0, 32'h1234_5678);
`else
        drive(1'b1, 5'd1, 5'd1, 5'd2, 5'd3, 32'h0);
`endif
        step();
        idle();
        check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_addr", out_addr, BASE);
        check_eq("mid_rst_instr", out_instr, 32'h0);
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("post_rst_no_word", {31'd0, out_valid}, 32'd0);
        end
        check_eq("post_rst_addr", out_addr, BASE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
